// File: rtl/uart_tx_pkg.sv
// Shared state encoding, line level and parity constants for the UART transmit path.
package uart_tx_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

   localparam logic TX_IDLE_LVL = 1'b1;
   localparam logic PAR_EVEN    = 1'b0;
   localparam logic PAR_ODD     = 1'b1;

   function automatic logic parity_bit(input logic data_xor, input logic par_typ);
      logic result;
      case (par_typ)
         PAR_EVEN: result = data_xor;
         PAR_ODD:  result = ~data_xor;
         default:  result = data_xor;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..PRESCALE and ticks on the last clock of each bit period.
module uart_baud_gen #(
   parameter int PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               clear,
   input  logic [PRESC_W-1:0] PRESCALE,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt;

   assign tick = (cnt == PRESCALE);

   // Clearing at frame start aligns the first bit period exactly with the START state.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter with one-entry holding register, runtime frame config and internal baud timer.
module uart_tx_gen
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [PRESC_W-1:0]    PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [DATA_WIDTH-1:0] S_DATA,
   input  logic                  S_VALID,
   output logic                  S_READY,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  FRAME_DONE
);

   localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   tx_state_e             state, state_nxt;
   logic [DATA_WIDTH-1:0] hold_data, shift_reg;
   logic                  hold_full;
   logic [PRESC_W-1:0]    presc_lat;
   logic                  par_en_lat, stop2_lat, par_lat;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  stop_cnt;
   logic                  tick, load, frame_end, accept, tx_nxt;

   assign S_READY = !hold_full;
   assign accept  = S_VALID && !hold_full;

   uart_baud_gen #(.PRESC_W(PRESC_W)) u_baud (
      .CLK      (CLK),
      .RST      (RST),
      .clear    (load),
      .PRESCALE (presc_lat),
      .tick     (tick)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The FSM runs one clock ahead of the pins; tx_nxt is the level for the next clock.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      frame_end = 1'b0;
      tx_nxt    = TX_IDLE_LVL;
      case (state)
         IDLE: begin
            if (hold_full) begin
               load      = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tx_nxt = 1'b0;
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shift_reg[0];
            if (tick && (bit_cnt == LAST_BIT)) state_nxt = par_en_lat ? PARITY : STOP;
         end
         PARITY: begin
            tx_nxt = par_lat;
            if (tick) state_nxt = STOP;
         end
         STOP: begin
            tx_nxt = 1'b1;
            if (tick && (!stop2_lat || stop_cnt)) begin
               frame_end = 1'b1;
               if (hold_full) begin
                  load      = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A new word wins over freeing the holding register so an accept during a load is never lost.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         hold_full  <= 1'b0;
         hold_data  <= '0;
         shift_reg  <= '0;
         presc_lat  <= '0;
         par_en_lat <= 1'b0;
         stop2_lat  <= 1'b0;
         par_lat    <= 1'b0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
      end else begin
         if (accept) begin
            hold_data <= S_DATA;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
         if (load) begin
            shift_reg  <= hold_data;
            presc_lat  <= PRESCALE;
            par_en_lat <= PAR_EN;
            stop2_lat  <= STOP2;
            par_lat    <= parity_bit(^hold_data, PAR_TYP);
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
         end else if (tick) begin
            if (state == DATA) begin
               shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
               bit_cnt   <= bit_cnt + 1'b1;
            end
            if (state == STOP) stop_cnt <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         TX_OUT     <= TX_IDLE_LVL;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         TX_OUT     <= tx_nxt;
         BUSY       <= (state != IDLE);
         FRAME_DONE <= frame_end;
      end
   end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: 8-bit main instance plus 9- and 5-bit builds behind a monitor mux.
module tb_uart_tx_gen;
   import uart_tx_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, par_en, par_typ, stop2, s_valid;
   logic [5:0] prescale;
   logic [8:0] s_data;
   logic [1:0] sel;
   logic       v8, v9, v5, r8, r9, r5, tx8, tx9, tx5, b8, b9, b5, d8, d9, d5;
   logic       mon_tx, mon_busy, mon_ready, mon_done;

   int          checks = 0;
   int          failures = 0;
   logic        wave[$];
   int          busy_len, done_cnt, ready_rises;
   logic        timed_out;
   logic [63:0] exp_vec, obs_vec;
   int          exp_len;
   logic        obs_stable;
   logic [8:0]  bp_q[$];

   always #5 clk = ~clk;

   assign v8 = s_valid && (sel == 2'd0);
   assign v9 = s_valid && (sel == 2'd1);
   assign v5 = s_valid && (sel == 2'd2);
   assign mon_tx    = (sel == 2'd1) ? tx9 : (sel == 2'd2) ? tx5 : tx8;
   assign mon_busy  = (sel == 2'd1) ? b9  : (sel == 2'd2) ? b5  : b8;
   assign mon_ready = (sel == 2'd1) ? r9  : (sel == 2'd2) ? r5  : r8;
   assign mon_done  = (sel == 2'd1) ? d9  : (sel == 2'd2) ? d5  : d8;

   uart_tx_gen #(.DATA_WIDTH(8), .PRESC_W(6)) dut8 (
      .CLK(clk), .RST(rst_n), .PRESCALE(prescale), .PAR_EN(par_en), .PAR_TYP(par_typ),
      .STOP2(stop2), .S_DATA(s_data[7:0]), .S_VALID(v8), .S_READY(r8), .TX_OUT(tx8),
      .BUSY(b8), .FRAME_DONE(d8));

   uart_tx_gen #(.DATA_WIDTH(9), .PRESC_W(6)) dut9 (
      .CLK(clk), .RST(rst_n), .PRESCALE(prescale), .PAR_EN(par_en), .PAR_TYP(par_typ),
      .STOP2(stop2), .S_DATA(s_data), .S_VALID(v9), .S_READY(r9), .TX_OUT(tx9),
      .BUSY(b9), .FRAME_DONE(d9));

   uart_tx_gen #(.DATA_WIDTH(5), .PRESC_W(6)) dut5 (
      .CLK(clk), .RST(rst_n), .PRESCALE(prescale), .PAR_EN(par_en), .PAR_TYP(par_typ),
      .STOP2(stop2), .S_DATA(s_data[4:0]), .S_VALID(v5), .S_READY(r5), .TX_OUT(tx5),
      .BUSY(b5), .FRAME_DONE(d5));

   task automatic set_cfg(input logic [5:0] p, input logic pe, input logic pt, input logic s2);
      prescale = p;
      par_en   = pe;
      par_typ  = pt;
      stop2    = s2;
   endtask

   // Reference frame builder: start, LSB-first data, optional parity, one or two stops.
   task automatic add_frame(input logic [8:0] d, input int w, input logic pe, input logic pt,
                            input logic s2);
      logic p;
      p = pt;
      exp_vec[exp_len] = 1'b0;
      exp_len++;
      for (int i = 0; i < w; i++) begin
         exp_vec[exp_len] = d[i];
         p = p ^ d[i];
         exp_len++;
      end
      if (pe) begin
         exp_vec[exp_len] = p;
         exp_len++;
      end
      exp_vec[exp_len] = 1'b1;
      exp_len++;
      if (s2) begin
         exp_vec[exp_len] = 1'b1;
         exp_len++;
      end
   endtask

   task automatic send_word(input logic [8:0] d, input logic keep_valid);
      int n;
      n = 0;
      @(negedge clk);
      s_data  = d;
      s_valid = 1'b1;
      while (!mon_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!mon_ready) begin
         failures++;
         $display("[TB] FAIL send_handshake ready=%b expected=1", mon_ready);
      end
      @(posedge clk);
      #1;
      if (!keep_valid) s_valid = 1'b0;
   endtask

   task automatic capture(input int limit);
      int   n;
      logic prev_ready;
      n = 0;
      wave.delete();
      done_cnt    = 0;
      ready_rises = 0;
      busy_len    = 0;
      timed_out   = 1'b0;
      @(negedge clk);
      while (!mon_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!mon_busy) begin
         timed_out = 1'b1;
         return;
      end
      n = 0;
      prev_ready = mon_ready;
      while (mon_busy && n < limit) begin
         wave.push_back(mon_tx);
         if (mon_done) done_cnt++;
         if (mon_ready && !prev_ready) ready_rises++;
         prev_ready = mon_ready;
         @(negedge clk);
         n++;
      end
      busy_len = n;
   endtask

   task automatic decode(input int p);
      obs_vec    = '0;
      obs_stable = 1'b1;
      for (int i = 0; i < wave.size(); i++) begin
         if (wave[i] !== wave[(i / (p + 1)) * (p + 1)]) obs_stable = 1'b0;
         if ((i / (p + 1)) < 64) obs_vec[i / (p + 1)] = wave[i];
      end
   endtask

   task automatic test_reset();
      int n;
      int idle_bad;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (tx8 !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b want=1", tx8); end
      checks++; if (b8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", b8); end
      checks++; if (r8 !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b want=1", r8); end
      checks++; if (d8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", d8); end
      rst_n = 1'b1;
      set_cfg(6'd3, 1'b0, PAR_EVEN, 1'b0);
      send_word(9'h0A5, 1'b0);
      send_word(9'h03C, 1'b0);
      n = 0;
      while (!b8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (9) @(negedge clk);
      checks++; if (tx8 !== 1'b0) begin failures++; $display("[TB] FAIL midframe_pre_tx got=%b want=0", tx8); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (tx8 !== 1'b1) begin failures++; $display("[TB] FAIL midreset_tx got=%b want=1", tx8); end
      checks++; if (b8 !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b want=0", b8); end
      checks++; if (r8 !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready got=%b want=1", r8); end
      @(negedge clk);
      rst_n = 1'b1;
      idle_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (b8 || !tx8) idle_bad++;
      end
      checks++; if (idle_bad != 0) begin failures++; $display("[TB] FAIL postreset_idle active_clocks=%0d want=0", idle_bad); end
   endtask

   task automatic test_latency();
      set_cfg(6'd0, 1'b0, PAR_EVEN, 1'b0);
      @(negedge clk);
      s_data  = 9'h081;
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(negedge clk);
      checks++; if (r8 !== 1'b0) begin failures++; $display("[TB] FAIL lat_ready_n1 got=%b want=0", r8); end
      checks++; if (b8 !== 1'b0) begin failures++; $display("[TB] FAIL lat_busy_n1 got=%b want=0", b8); end
      @(negedge clk);
      checks++; if (r8 !== 1'b1) begin failures++; $display("[TB] FAIL lat_ready_n2 got=%b want=1", r8); end
      checks++; if (tx8 !== 1'b1) begin failures++; $display("[TB] FAIL lat_tx_n2 got=%b want=1", tx8); end
      @(negedge clk);
      checks++; if (tx8 !== 1'b0) begin failures++; $display("[TB] FAIL lat_tx_n3 got=%b want=0", tx8); end
      checks++; if (b8 !== 1'b1) begin failures++; $display("[TB] FAIL lat_busy_n3 got=%b want=1", b8); end
      capture(100);
      checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL lat_done got=%0d want=1", done_cnt); end
   endtask

   task automatic test_8n1();
      set_cfg(6'd3, 1'b0, PAR_EVEN, 1'b0);
      send_word(9'h0A5, 1'b0);
      capture(100);
      decode(3);
      checks++;
      if (obs_vec !== 64'h34A || !obs_stable) begin
         failures++;
         $display("[TB] FAIL frame_8n1 got=%h stable=%b want=%h", obs_vec, obs_stable, 64'h34A);
      end
      checks++; if (busy_len != 40) begin failures++; $display("[TB] FAIL busy_8n1 got=%0d want=40", busy_len); end
      checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL done_8n1 got=%0d want=1", done_cnt); end
   endtask

   task automatic test_parity();
      logic [7:0] pd[3]      = '{8'h07, 8'h07, 8'h00};
      logic       pt_t[3]    = '{PAR_EVEN, PAR_ODD, PAR_ODD};
      logic       s2_t[3]    = '{1'b0, 1'b0, 1'b1};
      logic       par_want[3] = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         set_cfg(6'd1, 1'b1, pt_t[k], s2_t[k]);
         send_word({1'b0, pd[k]}, 1'b0);
         capture(100);
         decode(1);
         exp_vec = '0;
         exp_len = 0;
         add_frame({1'b0, pd[k]}, 8, 1'b1, pt_t[k], s2_t[k]);
         checks++;
         if (obs_vec !== exp_vec || !obs_stable) begin
            failures++;
            $display("[TB] FAIL frame_par%0d got=%h stable=%b want=%h", k, obs_vec, obs_stable, exp_vec);
         end
         checks++;
         if (obs_vec[9] !== par_want[k]) begin
            failures++;
            $display("[TB] FAIL parity_bit%0d got=%b want=%b", k, obs_vec[9], par_want[k]);
         end
         checks++;
         if (busy_len != exp_len * 2) begin
            failures++;
            $display("[TB] FAIL busy_par%0d got=%0d want=%0d", k, busy_len, exp_len * 2);
         end
         checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL done_par%0d got=%0d want=1", k, done_cnt); end
      end
   endtask

   task automatic test_back_to_back();
      set_cfg(6'd0, 1'b0, PAR_EVEN, 1'b0);
      fork
         begin
            send_word(9'h011, 1'b1);
            send_word(9'h022, 1'b1);
            send_word(9'h033, 1'b1);
            s_valid = 1'b0;
         end
         capture(100);
      join
      decode(0);
      exp_vec = '0;
      exp_len = 0;
      add_frame(9'h011, 8, 1'b0, PAR_EVEN, 1'b0);
      add_frame(9'h022, 8, 1'b0, PAR_EVEN, 1'b0);
      add_frame(9'h033, 8, 1'b0, PAR_EVEN, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
         failures++;
         $display("[TB] FAIL frame_b2b got=%h want=%h", obs_vec, exp_vec);
      end
      checks++; if (busy_len != 30) begin failures++; $display("[TB] FAIL busy_b2b got=%0d want=30", busy_len); end
      checks++; if (done_cnt != 3) begin failures++; $display("[TB] FAIL done_b2b got=%0d want=3", done_cnt); end
      checks++; if (ready_rises != 2) begin failures++; $display("[TB] FAIL ready_b2b rises=%0d want=2", ready_rises); end
   endtask

   task automatic test_backpressure();
      set_cfg(6'd0, 1'b0, PAR_EVEN, 1'b0);
      bp_q.delete();
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               @(negedge clk);
               s_data  = 9'h040 + 9'(k);
               s_valid = 1'b1;
               if (mon_ready) bp_q.push_back(s_data);
            end
            @(negedge clk);
            s_valid = 1'b0;
         end
         capture(200);
      join
      decode(0);
      exp_vec = '0;
      exp_len = 0;
      foreach (bp_q[i]) add_frame(bp_q[i], 8, 1'b0, PAR_EVEN, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
         failures++;
         $display("[TB] FAIL frame_bp got=%h want=%h", obs_vec, exp_vec);
      end
      checks++; if (busy_len != exp_len) begin failures++; $display("[TB] FAIL busy_bp got=%0d want=%0d", busy_len, exp_len); end
      checks++; if (done_cnt != bp_q.size()) begin failures++; $display("[TB] FAIL done_bp got=%0d want=%0d", done_cnt, bp_q.size()); end
   endtask

   task automatic test_config_change();
      set_cfg(6'd1, 1'b1, PAR_EVEN, 1'b1);
      send_word(9'h05A, 1'b0);
      @(posedge clk);
      #1 set_cfg(6'd0, 1'b0, PAR_ODD, 1'b0);
      capture(100);
      decode(1);
      exp_vec = '0;
      exp_len = 0;
      add_frame(9'h05A, 8, 1'b1, PAR_EVEN, 1'b1);
      checks++;
      if (obs_vec !== exp_vec || !obs_stable) begin
         failures++;
         $display("[TB] FAIL frame_cfg got=%h stable=%b want=%h", obs_vec, obs_stable, exp_vec);
      end
      checks++; if (busy_len != 24) begin failures++; $display("[TB] FAIL busy_cfg got=%0d want=24", busy_len); end
      checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL done_cfg got=%0d want=1", done_cnt); end
   endtask

   task automatic test_widths();
      sel = 2'd1;
      set_cfg(6'd63, 1'b0, PAR_EVEN, 1'b0);
      send_word(9'h1A5, 1'b0);
      capture(1000);
      decode(63);
      exp_vec = '0;
      exp_len = 0;
      add_frame(9'h1A5, 9, 1'b0, PAR_EVEN, 1'b0);
      checks++;
      if (obs_vec !== exp_vec || !obs_stable) begin
         failures++;
         $display("[TB] FAIL frame_w9 got=%h stable=%b want=%h", obs_vec, obs_stable, exp_vec);
      end
      checks++; if (busy_len != 704) begin failures++; $display("[TB] FAIL busy_w9 got=%0d want=704", busy_len); end
      checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL done_w9 got=%0d want=1", done_cnt); end
      sel = 2'd2;
      send_word(9'h016, 1'b0);
      @(posedge clk);
      #1 set_cfg(6'd63, 1'b1, PAR_ODD, 1'b1);
      capture(1000);
      decode(63);
      exp_vec = '0;
      exp_len = 0;
      add_frame(9'h016, 5, 1'b0, PAR_EVEN, 1'b0);
      checks++;
      if (obs_vec !== exp_vec || !obs_stable) begin
         failures++;
         $display("[TB] FAIL frame_w5 got=%h stable=%b want=%h", obs_vec, obs_stable, exp_vec);
      end
      checks++; if (busy_len != 448) begin failures++; $display("[TB] FAIL busy_w5 got=%0d want=448", busy_len); end
      checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL done_w5 got=%0d want=1", done_cnt); end
      sel = 2'd0;
   endtask

   initial begin
      sel     = 2'd0;
      s_valid = 1'b0;
      s_data  = '0;
      rst_n   = 1'b0;
      set_cfg(6'd0, 1'b0, PAR_EVEN, 1'b0);
      test_reset();
      test_latency();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_backpressure();
      test_config_change();
      test_widths();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
